// File: rtl/mem_bus_master_pkg.sv
// Types and helpers for the memory bus initiator (geometry comes from param.vh).
package mem_bus_master_pkg;
  `include "param.vh"

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    WRITE = ST_WRITE,
    READ  = ST_READ,
    DRAIN = ST_DRAIN,
    DONE  = ST_DONE
  } state_e;

  // Next word address, wrapping at the top of the memory.
  function automatic logic [ADDR_BITS-1:0] addr_inc(input logic [ADDR_BITS-1:0] a);
    return (a == ADDR_BITS'(MEM_SIZE - 1)) ? '0 : a + 1'b1;
  endfunction
endpackage

// File: rtl/mem_bus_master_if.sv
// Core-side request/beat handshakes plus the memory strobes of mem_bus_master.
interface mem_bus_master_if;
  import mem_bus_master_pkg::*;

  logic                    req_valid, req_ready, req_we;
  logic [ADDR_BITS-1:0]    req_addr;
  logic [MAX_LEN_BITS-1:0] req_len;
  logic                    wr_valid, wr_ready;
  logic [DATA_BITS-1:0]    wr_data;
  logic                    rd_valid;
  logic [DATA_BITS-1:0]    rd_data;
  logic                    done, err_rom;
  logic                    mem_cs, mem_we;
  logic [ADDR_BITS-1:0]    mem_addr;
  logic [DATA_BITS-1:0]    mem_wdata, mem_rdata;

  modport master (
    input  req_valid, req_we, req_addr, req_len, wr_valid, wr_data, mem_rdata,
    output req_ready, wr_ready, rd_valid, rd_data, done, err_rom,
           mem_cs, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output req_valid, req_we, req_addr, req_len, wr_valid, wr_data, mem_rdata,
    input  req_ready, wr_ready, rd_valid, rd_data, done, err_rom,
           mem_cs, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_bus_master_rdpipe.sv
// Read-return pipe: tags each issued read beat and captures its data two cycles later.
module mem_bus_master_rdpipe
  import mem_bus_master_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 issue,
  input  logic [DATA_BITS-1:0] mem_rdata,
  output logic                 rd_valid,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 empty
);
  localparam int STAGES = 2;

  logic [STAGES:1] vld_q;
  logic [STAGES:0] vld_pipe;

  assign vld_pipe = {vld_q, issue};

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      vld_q   <= '0;
      rd_data <= '0;
    end else begin
      vld_q <= vld_pipe[STAGES-1:0];
      // memory data for a beat is on mem_rdata while its tag sits in the middle stage
      if (vld_pipe[STAGES-1]) rd_data <= mem_rdata;
    end
  end

  assign rd_valid = vld_pipe[STAGES];
  // the beat currently on rd_valid is already delivered; only earlier stages count
  assign empty    = ~|vld_pipe[STAGES-1:0];
endmodule

// File: rtl/param.vh
// Shared memory-bus geometry and FSM state encodings for mem_bus_master.
// Pulled into mem_bus_master_pkg; other files see these through the package.
localparam int ADDR_BITS    = 8;
localparam int DATA_BITS    = 8;
localparam int MEM_SIZE     = 256;
localparam int ROM_SIZE     = 128;
localparam int MAX_LEN_BITS = 4;

localparam logic [2:0] ST_IDLE  = 3'd0;
localparam logic [2:0] ST_WRITE = 3'd1;
localparam logic [2:0] ST_READ  = 3'd2;
localparam logic [2:0] ST_DRAIN = 3'd3;
localparam logic [2:0] ST_DONE  = 3'd4;

// File: rtl/mem_bus_master.sv
// Burst initiator for the shared ROM/RAM bus; sole driver of CS/WE/addr/wdata.
// Optional: MEM_BUS_MASTER_ROM_GUARD_EN suppresses write beats into ROM and pulses err_rom.
module mem_bus_master
  import mem_bus_master_pkg::*;
(
  input logic               CLK,
  input logic               RESET,
  mem_bus_master_if.master  bus
);
  state_e                  state, state_d;
  logic [ADDR_BITS-1:0]    cur_addr, cur_addr_d;
  logic [MAX_LEN_BITS-1:0] beats_left, beats_left_d;
  logic                    wr_hs, last, rom_hit, pipe_empty;

  logic                    req_ready_d, wr_ready_d, done_d, err_rom_d, mem_cs_d, mem_we_d;
  logic [ADDR_BITS-1:0]    mem_addr_d;
  logic [DATA_BITS-1:0]    mem_wdata_d;

  assign wr_hs = (state == WRITE) && bus.wr_valid && bus.wr_ready;
  assign last  = (beats_left == '0);

`ifdef MEM_BUS_MASTER_ROM_GUARD_EN
  assign rom_hit = (32'(cur_addr) < ROM_SIZE);
`else
  assign rom_hit = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (bus.req_valid) state_d = bus.req_we ? WRITE : READ;
      WRITE:   if (wr_hs && last) state_d = DONE;
      READ:    if (last)          state_d = DRAIN;
      DRAIN:   if (pipe_empty)    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values for the address/count datapath and the registered outputs.
  always_comb begin
    cur_addr_d   = cur_addr;
    beats_left_d = beats_left;
    mem_cs_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = bus.mem_addr;
    mem_wdata_d  = bus.mem_wdata;
    err_rom_d    = 1'b0;
    case (state)
      IDLE: if (bus.req_valid) begin
        cur_addr_d   = bus.req_addr;
        beats_left_d = bus.req_len;
      end
      WRITE: if (wr_hs) begin
        cur_addr_d   = addr_inc(cur_addr);
        beats_left_d = beats_left - 1'b1;
        if (rom_hit) begin
          err_rom_d = 1'b1;
        end else begin
          mem_cs_d    = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = cur_addr;
          mem_wdata_d = bus.wr_data;
        end
      end
      READ: begin
        cur_addr_d   = addr_inc(cur_addr);
        beats_left_d = beats_left - 1'b1;
        mem_cs_d     = 1'b1;
        mem_addr_d   = cur_addr;
      end
      default: ;
    endcase
    req_ready_d = (state_d == IDLE);
    wr_ready_d  = (state_d == WRITE);
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cur_addr      <= '0;
      beats_left    <= '0;
      bus.req_ready <= 1'b1;
      bus.wr_ready  <= 1'b0;
      bus.done      <= 1'b0;
      bus.err_rom   <= 1'b0;
      bus.mem_cs    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      cur_addr      <= cur_addr_d;
      beats_left    <= beats_left_d;
      bus.req_ready <= req_ready_d;
      bus.wr_ready  <= wr_ready_d;
      bus.done      <= done_d;
      bus.err_rom   <= err_rom_d;
      bus.mem_cs    <= mem_cs_d;
      bus.mem_we    <= mem_we_d;
      bus.mem_addr  <= mem_addr_d;
      bus.mem_wdata <= mem_wdata_d;
    end
  end

  mem_bus_master_rdpipe u_rdpipe (
    .CLK       (CLK),
    .RESET     (RESET),
    .issue     (bus.mem_cs & ~bus.mem_we),
    .mem_rdata (bus.mem_rdata),
    .rd_valid  (bus.rd_valid),
    .rd_data   (bus.rd_data),
    .empty     (pipe_empty)
  );
endmodule

// File: tb/tb_mem_bus_master.sv
// Bench for mem_bus_master: memory model, bus monitor, table + random bursts vs a word-level model.
module tb_mem_bus_master;
  import mem_bus_master_pkg::*;

`ifdef MEM_BUS_MASTER_ROM_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  mem_bus_master_if bus();
  mem_bus_master dut (.CLK(CLK), .RESET(RESET), .bus(bus));

  int total = 0, bad = 0, cyc = 0;

  // memory: registered read, write on CS&WE
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  always @(posedge CLK)
    if (bus.mem_cs) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata <= mem[bus.mem_addr];
    end

  typedef struct { int cyc; logic we; logic [7:0] addr; logic [7:0] dat; } ev_t;
  ev_t cs_q[$], rd_q[$];
  int  done_q[$], err_q[$];

  always @(negedge CLK) begin
    cyc = cyc + 1;
    if (bus.mem_cs)   cs_q.push_back('{cyc, bus.mem_we, bus.mem_addr, bus.mem_wdata});
    if (bus.rd_valid) rd_q.push_back('{cyc, 1'b0, 8'h00, bus.rd_data});
    if (bus.done)     done_q.push_back(cyc);
    if (bus.err_rom)  err_q.push_back(cyc);
  end

  logic [7:0] wbuf [16];
  int         hs_cyc [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic run_burst(input bit we, input logic [7:0] a, input logic [3:0] l,
                           input int gap, input bit noise);
    int beat, gcnt, n;
    bit hs;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 100) begin @(posedge CLK); #1; n++; end
    cs_q.delete(); rd_q.delete(); done_q.delete(); err_q.delete();
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = a; bus.req_len = l;
    @(posedge CLK); #1;
    bus.req_valid = 1'b0;
    if (noise) begin
      // request while busy must be dropped
      bus.req_valid = 1'b1; bus.req_we = ~we; bus.req_addr = a + 8'd7;
      @(posedge CLK); #1;
      bus.req_valid = 1'b0;
    end
    if (we) begin
      beat = 0; gcnt = 0; n = 0;
      while (beat <= int'(l) && n < 300) begin
        if (gcnt > 0) begin bus.wr_valid = 1'b0; gcnt--; end
        else begin bus.wr_valid = 1'b1; bus.wr_data = wbuf[beat]; end
        hs = bus.wr_valid && bus.wr_ready;
        if (hs) hs_cyc[beat] = cyc;
        @(posedge CLK); #1; n++;
        if (hs) begin beat++; gcnt = gap; end
      end
      bus.wr_valid = 1'b0;
      if (beat <= int'(l)) chk("wr_handshake_timeout", beat, int'(l) + 1);
    end
    n = 0;
    while (!(done_q.size() > 0 && bus.req_ready === 1'b1) && n < 100) begin
      @(posedge CLK); #1; n++;
    end
    chk("req_ready_back", bus.req_ready, 1);
    repeat (3) @(posedge CLK);
    #1;
  endtask

  task automatic check_burst(input bit we, input logic [7:0] a, input logic [3:0] l,
                             input string tg);
    int nb, ncs, nerr, ad;
    nb = int'(l) + 1; ncs = 0; nerr = 0;
    for (int i = 0; i < nb; i++) begin
      ad = (int'(a) + i) % MEM_SIZE;
      if (we && GUARD && ad < ROM_SIZE) begin
        if (nerr < err_q.size()) chk($sformatf("%s_err_cyc%0d", tg, i), err_q[nerr], hs_cyc[i] + 2);
        nerr++;
      end else begin
        if (we) ref_mem[ad] = wbuf[i];
        if (ncs < cs_q.size()) begin
          chk($sformatf("%s_cs_addr%0d", tg, i), cs_q[ncs].addr, ad);
          chk($sformatf("%s_cs_we%0d", tg, i), cs_q[ncs].we, we);
          if (we) begin
            chk($sformatf("%s_cs_wdata%0d", tg, i), cs_q[ncs].dat, wbuf[i]);
            chk($sformatf("%s_cs_cyc%0d", tg, i), cs_q[ncs].cyc, hs_cyc[i] + 2);
          end else if (i > 0) begin
            chk($sformatf("%s_cs_cyc%0d", tg, i), cs_q[ncs].cyc, cs_q[0].cyc + i);
          end
        end
        if (!we && i < rd_q.size() && cs_q.size() > 0) begin
          chk($sformatf("%s_rd_cyc%0d", tg, i), rd_q[i].cyc, cs_q[0].cyc + 2 + i);
          chk($sformatf("%s_rd_data%0d", tg, i), rd_q[i].dat, ref_mem[ad]);
        end
        ncs++;
      end
    end
    chk({tg, "_cs_count"}, cs_q.size(), ncs);
    chk({tg, "_err_count"}, err_q.size(), nerr);
    chk({tg, "_rd_count"}, rd_q.size(), we ? 0 : nb);
    chk({tg, "_done_count"}, done_q.size(), 1);
    if (!we && done_q.size() > 0 && rd_q.size() > 0)
      chk({tg, "_done_after_rd"}, done_q[0] > rd_q[rd_q.size()-1].cyc, 1);
  endtask

  typedef struct {
    bit we; logic [7:0] addr; logic [3:0] len; int gap; logic [7:0] dbase; bit noise;
    int exp_cs; int exp_err;
  } vec_t;
  localparam int NV = 11;
  vec_t tbl [NV];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_len = '0;
    bus.wr_valid  = 1'b0; bus.wr_data = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'((i * 7 + 3) & 8'hFF);
      ref_mem[i] = 8'((i * 7 + 3) & 8'hFF);
    end

    #1 RESET = 1'b0;
    #1;
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_wr_ready", bus.wr_ready, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err_rom", bus.err_rom, 0);
    chk("rst_mem_cs", bus.mem_cs, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    repeat (2) @(negedge CLK);
    #2 RESET = 1'b1;
    @(posedge CLK); #1;

    tbl[0]  = '{1'b1, 8'h80, 4'd3,  0, 8'h11, 1'b0, 4, 0};
    tbl[1]  = '{1'b0, 8'h80, 4'd3,  0, 8'h00, 1'b0, 4, 0};
    tbl[2]  = '{1'b1, 8'h90, 4'd3,  2, 8'h21, 1'b0, 4, 0};
    tbl[3]  = '{1'b0, 8'h90, 4'd3,  0, 8'h00, 1'b1, 4, 0};
    tbl[4]  = '{1'b0, 8'hFE, 4'd3,  0, 8'h00, 1'b0, 4, 0};
    tbl[5]  = '{1'b1, 8'h10, 4'd0,  0, 8'h5C, 1'b0, GUARD ? 0 : 1, GUARD ? 1 : 0};
    tbl[6]  = '{1'b1, 8'hFF, 4'd1,  1, 8'hA0, 1'b0, GUARD ? 1 : 2, GUARD ? 1 : 0};
    tbl[7]  = '{1'b0, 8'hFF, 4'd1,  0, 8'h00, 1'b0, 2, 0};
    tbl[8]  = '{1'b0, 8'h10, 4'd0,  0, 8'h00, 1'b1, 1, 0};
    tbl[9]  = '{1'b1, 8'h7E, 4'd3,  0, 8'hC3, 1'b0, GUARD ? 2 : 4, GUARD ? 2 : 0};
    tbl[10] = '{1'b0, 8'h7C, 4'd15, 0, 8'h00, 1'b0, 16, 0};

    for (int k = 0; k < NV; k++) begin
      for (int i = 0; i < 16; i++) wbuf[i] = tbl[k].dbase + 8'(i * 17);
      run_burst(tbl[k].we, tbl[k].addr, tbl[k].len, tbl[k].gap, tbl[k].noise);
      check_burst(tbl[k].we, tbl[k].addr, tbl[k].len, $sformatf("v%0d", k));
      chk($sformatf("v%0d_tbl_cs", k), cs_q.size(), tbl[k].exp_cs);
      chk($sformatf("v%0d_tbl_err", k), err_q.size(), tbl[k].exp_err);
    end

    // reset during beat 2 of a 4-beat read
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 100) begin @(posedge CLK); #1; n++; end
    cs_q.delete(); rd_q.delete(); done_q.delete(); err_q.delete();
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 8'h80; bus.req_len = 4'd3;
    @(posedge CLK); #1;
    bus.req_valid = 1'b0;
    n = 0;
    while (cs_q.size() < 2 && n < 50) begin @(negedge CLK); #1; n++; end
    chk("rst_mid_reached_beat2", cs_q.size(), 2);
    RESET = 1'b0;
    #1;
    chk("rst_mid_mem_cs", bus.mem_cs, 0);
    chk("rst_mid_rd_valid", bus.rd_valid, 0);
    chk("rst_mid_req_ready", bus.req_ready, 1);
    chk("rst_mid_mem_addr", bus.mem_addr, 0);
    cs_q.delete(); rd_q.delete(); done_q.delete(); err_q.delete();
    repeat (2) @(negedge CLK);
    #2 RESET = 1'b1;
    repeat (6) @(posedge CLK);
    #1;
    chk("rst_mid_no_cs", cs_q.size(), 0);
    chk("rst_mid_no_rd", rd_q.size(), 0);
    chk("rst_mid_no_done", done_q.size(), 0);
    chk("rst_mid_ready_after", bus.req_ready, 1);
    run_burst(1'b0, 8'h81, 4'd2, 0, 1'b0);
    check_burst(1'b0, 8'h81, 4'd2, "after_rst");

    for (int r = 0; r < 40; r++) begin
      bit         rwe;
      logic [7:0] ra;
      logic [3:0] rl;
      int         rg;
      rwe = 1'($urandom_range(0, 1));
      ra  = 8'($urandom);
      rl  = 4'($urandom);
      rg  = int'($urandom_range(0, 2));
      for (int i = 0; i < 16; i++) wbuf[i] = 8'($urandom);
      run_burst(rwe, ra, rl, rg, !rwe && ($urandom_range(0, 1) == 1));
      check_burst(rwe, ra, rl, $sformatf("r%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_bus_master.md
Name: mem_bus_master

Overview:
- Initiator for the shared ROM/RAM memory bus (addr / in_dat / WE / CS / o_dat).
- Accepts single or burst read/write requests from a core-side valid/ready interface and sequences the memory control strobes.
- Returns read data with a valid strobe and signals completion.
- Sits between the CPU/loader logic and the memory block; it is the only driver of the memory's CS/WE/addr/in_dat.

Parameters:
- ADDR_BITS, 8, memory address width (from the shared include).
- DATA_BITS, 8, data width.
- MEM_SIZE, 256, total words; address arithmetic wraps modulo MEM_SIZE.
- ROM_SIZE, 128, words [0, ROM_SIZE-1] are read-only.
- MAX_LEN_BITS, 4, width of the burst length field (bursts of 1 to 16 beats).

Ports:
- CLK  in  1  clock.
- RESET  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  master idle, can accept a request.
- req_we  in  1  1 = write burst, 0 = read burst.
- req_addr  in  ADDR_BITS  start address.
- req_len  in  MAX_LEN_BITS  beats minus 1.
- wr_valid  in  1  write beat data present.
- wr_ready  out  1  master accepts a write beat.
- wr_data  in  DATA_BITS  write beat data.
- rd_valid  out  1  rd_data valid this cycle; no backpressure.
- rd_data  out  DATA_BITS  read beat data.
- done  out  1  one-cycle pulse at burst end.
- err_rom  out  1  one-cycle pulse when a ROM write beat is suppressed.
- mem_cs  out  1  memory chip select.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_BITS  memory address.
- mem_wdata  out  DATA_BITS  memory write data.
- mem_rdata  in  DATA_BITS  memory registered read data.

Behaviour:
- Interface: reset RESET, asynchronous, active-low; clock CLK.
- All outputs are registered.
- Reset values:
  - req_ready=1 (state IDLE).
  - wr_ready, rd_valid, done, err_rom, mem_cs, mem_we = 0.
  - mem_addr, mem_wdata, rd_data = 0.
  - Beat counter = 0; read-valid pipe cleared.
- Memory timing: memory samples CS/WE/addr at posedge; read data appears on mem_rdata after the edge that sampled CS=1, WE=0.
- FSM states: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid: latch cur_addr=req_addr, beats_left=req_len.
  - Go to WRITE if req_we=1, else READ.
  - req_ready drops the cycle after acceptance.
- WRITE:
  - wr_ready=1.
  - Each wr_valid&wr_ready handshake drives mem_cs=1, mem_we=1, mem_addr=cur_addr, mem_wdata=wr_data for exactly the next cycle.
  - Without a handshake, mem_cs=0.
  - cur_addr increments by 1 with wrap MEM_SIZE-1 -> 0.
  - On the handshake with beats_left=0, go to DONE and drop wr_ready the next cycle.
- READ:
  - Issues one beat per cycle, back-to-back: mem_cs=1, mem_we=0, mem_addr=cur_addr.
  - Address increments with wrap.
  - After issuing the last beat, go to DRAIN.
- Read return:
  - A 2-stage valid pipe tags issued beats.
  - rd_valid=1, with rd_data=mem_rdata registered, 2 cycles after each beat's mem_cs cycle.
  - An N-beat read yields N consecutive rd_valid cycles.
- DRAIN: mem_cs=0; wait until the valid pipe is empty, then go to DONE.
- DONE: done=1 for one cycle, mem_cs=0, then IDLE.
- Single beat (req_len=0):
  - Write: 1 mem_cs cycle.
  - Read: rd_valid 2 cycles after the mem_cs cycle, then done.
- req_valid outside IDLE is ignored, not queued.
- Address wrap mid-burst (e.g. start 0xFE, len 3): addresses 0xFE, 0xFF, 0x00, 0x01.
- RESET asserted mid-burst:
  - Aborts immediately; outputs go to reset values.
  - No done pulse and no further mem_cs.
  - In-flight read data is discarded.

Optional Feature:
- Macro: MEM_BUS_MASTER_ROM_GUARD_EN.
- Defined:
  - A write beat whose cur_addr < ROM_SIZE still completes its wr handshake and advances the address.
  - mem_cs stays 0 for that beat.
  - err_rom pulses 1 in the cycle the beat would have been driven.
- Undefined: the beat is driven to memory unchanged, and err_rom is tied 0.

Decomposition:
- Shared include param.vh holds ADDR_BITS, DATA_BITS, MEM_SIZE, ROM_SIZE and MAX_LEN_BITS (add it), plus the FSM state encodings.
- One sub-module, mem_bus_master_rdpipe: the 2-stage read valid/data capture pipe, with inputs issue and mem_rdata, outputs rd_valid and rd_data, and an empty flag used by DRAIN.

Test Plan:
- Reset, then write burst addr 0x80, len 3, data 11,22,33,44 with wr_valid held high -> mem_cs/mem_we high on 4 consecutive cycles at addr 0x80..0x83; done pulses once; req_ready returns to 1.
- Read burst addr 0x80, len 3 after the above -> 4 consecutive mem_cs cycles with mem_we=0; rd_valid on 4 consecutive cycles starting 2 cycles after the first mem_cs, carrying 11,22,33,44.
- Write with wr_valid gaps (beats 2 and 3 each separated by 2 idle cycles) -> mem_cs only in the handshake-following cycles; address still sequential.
- Read addr 0xFE, len 3 -> mem_addr 0xFE, 0xFF, 0x00, 0x01; 4 rd_valid pulses.
- Write addr 0x10 (ROM), len 0, with the guard enabled -> mem_cs stays 0, err_rom=1 for one cycle, done pulses. Guard disabled -> mem_cs=1, mem_we=1, err_rom=0.
- RESET low during beat 2 of a 4-beat read -> mem_cs=0 and rd_valid=0 immediately; no done; req_ready=1 after release; a new request is accepted normally.
